branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage BTB with 2-bit saturating direction counters, trained from Decode.
// Optional same-cycle write-to-lookup bypass when BP_FWD_EN is defined.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        HitF,
  output logic [31:0] PredPCF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        HitD,
  input  logic [31:0] PCD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        PCSrcD,
  input  logic [31:0] TargetD
);

  localparam int unsigned Depth  = 2 ** IDX_BITS;
  localparam int unsigned TagLsb = IDX_BITS + 2;
  localparam int unsigned TagMsb = IDX_BITS + TAG_BITS + 1;

  logic [Depth-1:0]    validQ;
  logic [TAG_BITS-1:0] tagQ    [Depth];
  logic [31:0]         targetQ [Depth];
  logic [1:0]          ctrQ    [Depth];
  logic                hitDQ;

  logic [IDX_BITS-1:0] idxF, idxD;
  logic [TAG_BITS-1:0] tagF, tagD;
  logic                matchF, matchD;
  logic                upd;
  logic                lookupHit;
  logic [31:0]         lookupTarget;

  logic                wrEn;
  logic                wrTargetEn;
  logic [1:0]          wrCtr;
  logic [31:0]         wrTarget;

  assign idxF = PCF[IDX_BITS+1:2];
  assign tagF = PCF[TagMsb:TagLsb];
  assign idxD = PCD[IDX_BITS+1:2];
  assign tagD = PCD[TagMsb:TagLsb];

  // Low byte-offset bits and PC bits above the tag never take part in lookup.
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCF[31:TagMsb+1], PCD[1:0], PCD[31:TagMsb+1]};

  assign matchF = validQ[idxF] && (tagQ[idxF] == tagF);
  assign matchD = validQ[idxD] && (tagQ[idxD] == tagD);

  // Gating on StallD gives one update per Decode instruction across stalls.
  assign upd = (BranchD | JumpD) & ~StallD;

  always_comb begin
    wrEn       = 1'b0;
    wrTargetEn = 1'b0;
    wrCtr      = ctrQ[idxD];
    wrTarget   = targetQ[idxD];
    if (upd) begin
      if (JumpD) begin
        wrEn       = 1'b1;
        wrTargetEn = 1'b1;
        wrCtr      = 2'b11;
        wrTarget   = TargetD;
      end else if (matchD) begin
        wrEn = 1'b1;
        if (PCSrcD) begin
          wrTargetEn = 1'b1;
          wrTarget   = TargetD;
          wrCtr      = (ctrQ[idxD] == 2'b11) ? 2'b11 : ctrQ[idxD] + 2'd1;
        end else begin
          wrCtr = (ctrQ[idxD] == 2'b00) ? 2'b00 : ctrQ[idxD] - 2'd1;
        end
      end else if (PCSrcD) begin
        wrEn       = 1'b1;
        wrTargetEn = 1'b1;
        wrTarget   = TargetD;
        wrCtr      = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validQ <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        ctrQ[i] <= 2'b01;
      end
    end else if (wrEn) begin
      validQ[idxD] <= 1'b1;
      ctrQ[idxD]   <= wrCtr;
    end
  end

  // Tag and target arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagQ[idxD] <= tagD;
    end
    if (wrTargetEn) begin
      targetQ[idxD] <= wrTarget;
    end
  end

`ifdef BP_FWD_EN
  logic fwd;
  assign fwd          = wrEn && !reset && (idxF == idxD) && (tagF == tagD);
  assign lookupHit    = fwd ? wrCtr[1] : (matchF && ctrQ[idxF][1]);
  assign lookupTarget = fwd ? wrTarget : targetQ[idxF];
`else
  assign lookupHit    = matchF && ctrQ[idxF][1];
  assign lookupTarget = targetQ[idxF];
`endif

  assign HitF    = lookupHit;
  assign PredPCF = lookupHit ? lookupTarget : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitDQ <= 1'b0;
    end else if (FlushD) begin
      hitDQ <= 1'b0;
    end else if (!StallD) begin
      hitDQ <= HitF;
    end
  end

  assign HitD = hitDQ;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected outputs are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_branch_predictor;

`ifdef BP_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  localparam logic [31:0] PcA    = 32'h0040_0010;
  localparam logic [31:0] PcB    = 32'h0040_0050; // same index as PcA, other tag
  localparam logic [31:0] PcC    = 32'h0040_0090; // same index as PcA, third tag
  localparam logic [31:0] PcJ    = 32'h0040_0100;
  localparam logic [31:0] PcPark = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PredPCF, PCD, TargetD;
  logic        HitF, StallD, FlushD, HitD, BranchD, JumpD, PCSrcD;

  typedef struct packed {
    logic        hit;
    logic [31:0] pred;
    logic        hitD;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  branch_predictor dut (
    .clk     (clk),
    .reset   (reset),
    .PCF     (PCF),
    .HitF    (HitF),
    .PredPCF (PredPCF),
    .StallD  (StallD),
    .FlushD  (FlushD),
    .HitD    (HitD),
    .PCD     (PCD),
    .BranchD (BranchD),
    .JumpD   (JumpD),
    .PCSrcD  (PCSrcD),
    .TargetD (TargetD)
  );

  always #5 clk = ~clk;

  task automatic want(input logic h, input logic [31:0] p, input logic d);
    exp_t e;
    e.hit  = h;
    e.pred = p;
    e.hitD = d;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    total++;
    assert (HitF === e.hit) else begin
      bad++;
      $error("FAIL %s.HitF observed=%0b expected=%0b", tag, HitF, e.hit);
    end
    total++;
    assert (PredPCF === e.pred) else begin
      bad++;
      $error("FAIL %s.PredPCF observed=%h expected=%h", tag, PredPCF, e.pred);
    end
    total++;
    assert (HitD === e.hitD) else begin
      bad++;
      $error("FAIL %s.HitD observed=%0b expected=%0b", tag, HitD, e.hitD);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One resolved branch in Decode; fetch is parked on an unrelated PC for the edge.
  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    logic [31:0] savedPcf;
    savedPcf = PCF;
    PCD      = pc;
    BranchD  = 1'b1;
    PCSrcD   = taken;
    TargetD  = tgt;
    PCF      = PcPark;
    step();
    BranchD  = 1'b0;
    PCF      = savedPcf;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PCF = PcA; PCD = '0; TargetD = '0;
    StallD = 1'b0; FlushD = 1'b0; BranchD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0;
    want(1'b0, 32'h0, 1'b0); check("reset");
    step();
    reset = 1'b0;
    want(1'b0, 32'h0, 1'b0); check("pre_train");

    train(PcA, 1'b1, 32'h0040_0040);
    want(1'b1, 32'h0040_0040, 1'b0); check("train_taken");
    step();
    want(1'b1, 32'h0040_0040, 1'b1); check("hitd_capture");
    train(PcA, 1'b0, 32'h0);
    want(1'b0, 32'h0, 1'b0); check("nt_once");
    train(PcA, 1'b1, 32'h0040_0040);
    train(PcA, 1'b1, 32'h0040_0040);
    want(1'b1, 32'h0040_0040, 1'b0); check("taken_twice");
    train(PcA, 1'b0, 32'h0);
    want(1'b1, 32'h0040_0040, 1'b0); check("nt_from_3");
    for (int i = 0; i < 3; i++) train(PcA, 1'b0, 32'h0);
    want(1'b0, 32'h0, 1'b0); check("sat_low");
    train(PcA, 1'b1, 32'h0040_0040);
    want(1'b0, 32'h0, 1'b0); check("inc_from_0");
    train(PcA, 1'b1, 32'h0040_0040);
    want(1'b1, 32'h0040_0040, 1'b0); check("inc_to_2");

    // Stalled not-taken branch must decrement the counter exactly once.
    step();
    FlushD = 1'b1; step(); FlushD = 1'b0;
    PCD = PcA; BranchD = 1'b1; PCSrcD = 1'b0; StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      want(1'b1, 32'h0040_0040, 1'b0); check("stall_hold");
    end
    StallD = 1'b0; PCF = PcPark;
    step();
    BranchD = 1'b0; PCF = PcA;
    want(1'b0, 32'h0, 1'b0); check("stall_release");
    train(PcA, 1'b1, 32'h0040_0040);
    want(1'b1, 32'h0040_0040, 1'b0); check("one_update");

    step();
    want(1'b1, 32'h0040_0040, 1'b1); check("hitd_again");
    FlushD = 1'b1; step(); FlushD = 1'b0;
    want(1'b1, 32'h0040_0040, 1'b0); check("flush");
    step();
    want(1'b1, 32'h0040_0040, 1'b1); check("no_flush");
    FlushD = 1'b1; StallD = 1'b1; step(); FlushD = 1'b0; StallD = 1'b0;
    want(1'b1, 32'h0040_0040, 1'b0); check("flush_over_stall");

    PCF = PcJ; PCD = PcJ; JumpD = 1'b1; TargetD = 32'h0040_0800;
    want(FwdEn, FwdEn ? 32'h0040_0800 : 32'h0, 1'b0); check("jump_same_cycle");
    step();
    JumpD = 1'b0;
    want(1'b1, 32'h0040_0800, FwdEn); check("jump_next");

    step();
    PCF = PcB;
    want(1'b0, 32'h0, 1'b1); check("tag_miss");
    train(PcB, 1'b1, 32'h0040_0200);
    want(1'b1, 32'h0040_0200, 1'b0); check("replace");
    PCF = PcA;
    want(1'b0, 32'h0, 1'b0); check("old_evicted");
    train(PcC, 1'b0, 32'h0040_0300);
    PCF = PcC;
    want(1'b0, 32'h0, 1'b0); check("nt_no_alloc");
    PCF = PcB;
    want(1'b1, 32'h0040_0200, 1'b0); check("nt_keep");

    step();
    want(1'b1, 32'h0040_0200, 1'b1); check("pre_reset");
    reset = 1'b1;
    want(1'b0, 32'h0, 1'b0); check("async_reset");
    step();
    reset = 1'b0; PCF = PcJ;
    want(1'b0, 32'h0, 1'b0); check("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
